// File: rtl/dispatch_group_buffer_pkg.sv
// rtl/dispatch_group_buffer_pkg.sv - shared op width and mask helpers for the dispatch group buffer
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 16
`endif
package dispatch_group_buffer_pkg;

    localparam int OP_SZ = `RENAMED_OP_SZ;
    localparam int MAX_W = 32;

    function automatic int unsigned popcount(input logic [MAX_W-1:0] m);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            c += 32'(m[i]);
        end
        return c;
    endfunction

    // Mask with the lowest n bits set; used to express "first n slots/ops".
    function automatic logic [MAX_W-1:0] low_mask(input int unsigned n);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/dispatch_compact.sv
// rtl/dispatch_compact.sv - survivor compaction: per-slot source select and survivor count
module dispatch_compact
    import dispatch_group_buffer_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_valid,
    input  logic [N-1:0]         i_retire,
    output logic [$clog2(N)-1:0] o_sel [N],
    output logic [$clog2(N):0]   o_surv_cnt
);

    localparam int IW = $clog2(N);

    logic [N-1:0]  w_mask  [N];
    logic [IW-1:0] w_idx   [N];
    logic          w_found [N];

    assign w_mask[0]  = i_valid & ~i_retire;
    assign o_surv_cnt = (IW + 1)'(popcount(MAX_W'(w_mask[0])));

    // Output slot j takes the j-th surviving slot: peel off the lowest survivor each stage.
    for (genvar j = 0; j < N; j++) begin : g_stage
        priority_enc #(.N(N)) u_penc (
            .i_req   (w_mask[j]),
            .o_idx   (w_idx[j]),
            .o_found (w_found[j])
        );
        assign o_sel[j] = w_found[j] ? w_idx[j] : '0;
        if (j < N - 1) begin : g_next
            assign w_mask[j+1] = w_found[j] ? (w_mask[j] & ~(N'(1) << w_idx[j])) : w_mask[j];
        end
    end

endmodule

// File: rtl/priority_enc.sv
// rtl/priority_enc.sv - lowest-index-first priority encoder
module priority_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = ($clog2(N))'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dispatch_group_buffer.sv
// rtl/dispatch_group_buffer.sv - retire/compact/refill holding buffer feeding the dispatch sorter
// Optional synchronous flush port enabled by DISPATCH_BUF_FLUSH_EN.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 16
`endif
module dispatch_group_buffer
    import dispatch_group_buffer_pkg::*;
#(
    parameter int FETCH_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
`ifdef DISPATCH_BUF_FLUSH_EN
    input  logic                                flush,
`endif
    input  logic [FETCH_WIDTH*`RENAMED_OP_SZ-1:0] in_ops,
    input  logic [FETCH_WIDTH-1:0]              in_valid,
    output logic [FETCH_WIDTH-1:0]              in_taken,
    output logic [FETCH_WIDTH*`RENAMED_OP_SZ-1:0] instr_out,
    output logic [FETCH_WIDTH-1:0]              instr_valid,
    input  logic [FETCH_WIDTH-1:0]              instr_used,
    output logic [$clog2(FETCH_WIDTH):0]        count
);

    localparam int FW = FETCH_WIDTH;
    localparam int IW = $clog2(FW);
    localparam int CW = IW + 1;
    localparam int SZ = `RENAMED_OP_SZ;

    logic [SZ-1:0] r_data [FW];
    logic [FW-1:0] r_valid;
    logic [CW-1:0] r_count;

    logic          w_flush;
    logic [FW-1:0] w_retire;
    logic [IW-1:0] w_sel [FW];
    logic [CW-1:0] w_surv;
    logic [CW-1:0] w_in_cnt;
    logic [CW-1:0] w_room;
    logic [CW-1:0] w_take_cnt;
    logic [FW-1:0] w_taken;
    logic [SZ-1:0] w_in_arr   [FW];
    logic [SZ-1:0] w_nxt_data [FW];
    logic [FW-1:0] w_nxt_valid;

`ifdef DISPATCH_BUF_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_retire = r_valid & instr_used;

    dispatch_compact #(.N(FW)) u_compact (
        .i_valid    (r_valid),
        .i_retire   (w_retire),
        .o_sel      (w_sel),
        .o_surv_cnt (w_surv)
    );

    assign w_in_cnt   = CW'(popcount(MAX_W'(in_valid)));
    assign w_room     = CW'(FW) - w_surv;
    assign w_take_cnt = (w_in_cnt < w_room) ? w_in_cnt : w_room;

    // Gated by rst_n so upstream never sees an acceptance while the buffer is held in reset.
    assign w_taken  = FW'(low_mask(32'(w_take_cnt))) & {FW{rst_n & ~w_flush}};
    assign in_taken = w_taken;

    for (genvar i = 0; i < FW; i++) begin : g_io
        assign w_in_arr[i]             = in_ops[i*SZ +: SZ];
        assign instr_out[i*SZ +: SZ]   = r_data[i];
    end

    always_comb begin
        for (int j = 0; j < FW; j++) begin
            w_nxt_data[j]  = '0;
            w_nxt_valid[j] = 1'b0;
            if (j < int'(w_surv)) begin
                w_nxt_data[j]  = r_data[w_sel[j]];
                w_nxt_valid[j] = 1'b1;
            end else if (j < int'(w_surv) + int'(w_take_cnt)) begin
                w_nxt_data[j]  = w_in_arr[IW'(j - int'(w_surv))];
                w_nxt_valid[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < FW; j++) begin
                r_data[j] <= '0;
            end
            r_valid <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            for (int j = 0; j < FW; j++) begin
                r_data[j] <= '0;
            end
            r_valid <= '0;
            r_count <= '0;
        end else begin
            for (int j = 0; j < FW; j++) begin
                r_data[j] <= w_nxt_data[j];
            end
            r_valid <= w_nxt_valid;
            r_count <= w_surv + w_take_cnt;
        end
    end

    assign instr_valid = r_valid;
    assign count       = r_count;

endmodule

// File: tb/tb_dispatch_group_buffer.sv
// tb/tb_dispatch_group_buffer.sv - self-checking bench for dispatch_group_buffer
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 16
`endif
module tb_dispatch_group_buffer;

    localparam int FW = 4;
    localparam int SZ = `RENAMED_OP_SZ;

    localparam logic [SZ-1:0] OA = SZ'(16'h00A1);
    localparam logic [SZ-1:0] OB = SZ'(16'h00B2);
    localparam logic [SZ-1:0] OC = SZ'(16'h00C3);
    localparam logic [SZ-1:0] OD = SZ'(16'h00D4);
    localparam logic [SZ-1:0] OE = SZ'(16'h00E5);
    localparam logic [SZ-1:0] OF = SZ'(16'h00F6);
    localparam logic [SZ-1:0] OG = SZ'(16'h0107);
    localparam logic [SZ-1:0] OH = SZ'(16'h0118);
    localparam logic [SZ-1:0] Z  = '0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [FW*SZ-1:0]  in_ops = '0;
    logic [FW-1:0]     in_valid = '0;
    logic [FW-1:0]     in_taken;
    logic [FW*SZ-1:0]  instr_out;
    logic [FW-1:0]     instr_valid;
    logic [FW-1:0]     instr_used = '0;
    logic [2:0]        count;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    logic [SZ-1:0] q[$];
    logic [FW-1:0] got_t;

    dispatch_group_buffer #(.FETCH_WIDTH(FW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef DISPATCH_BUF_FLUSH_EN
        .flush       (flush),
`endif
        .in_ops      (in_ops),
        .in_valid    (in_valid),
        .in_taken    (in_taken),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_used  (instr_used),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [FW*SZ-1:0] p4(input logic [SZ-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Registered outputs checked against the queue model away from the rising edge.
    always @(negedge clk) begin
        logic [FW*SZ-1:0] eo;
        logic [FW-1:0]    ev;
        if (chk_en) begin
            eo = '0;
            ev = '0;
            foreach (q[i]) begin
                eo[i*SZ +: SZ] = q[i];
                ev[i]          = 1'b1;
            end
            check("count", 64'(count), 64'(q.size()));
            check("instr_valid", 64'(instr_valid), 64'(ev));
            check("instr_out", 64'(instr_out), 64'(eo));
        end
    end

    task automatic cycle(input logic [FW-1:0] vld, input logic [FW*SZ-1:0] ops,
                         input logic [FW-1:0] used, input logic fl, output logic [FW-1:0] taken);
        logic [SZ-1:0] surv[$];
        int nin, room, k;
        logic [FW-1:0] exp_t;
        in_valid   = vld;
        in_ops     = ops;
        instr_used = used;
        flush      = fl;
        #1;
        foreach (q[i]) if (!used[i]) surv.push_back(q[i]);
        nin  = $countones(vld);
        room = FW - surv.size();
        k    = (nin < room) ? nin : room;
        if (fl || !rst_n) k = 0;
        exp_t = FW'((1 << k) - 1);
        taken = in_taken;
        check("in_taken", 64'(in_taken), 64'(exp_t));
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            q = surv;
            for (int i = 0; i < k; i++) q.push_back(ops[i*SZ +: SZ]);
        end
        #1;
        flush = 1'b0;
    endtask

    logic [FW-1:0] tbl_vld  [6] = '{4'b1111, 4'b0001, 4'b0011, 4'b1111, 4'b0000, 4'b0111};
    logic [FW-1:0] tbl_used [6] = '{4'b0001, 4'b1000, 4'b0110, 4'b1111, 4'b0010, 4'b1010};

    initial begin
        chk_en     = 1'b1;
        in_valid   = 4'b1111;
        in_ops     = p4(OA, OB, OC, OD);
        #1;
        check("reset_in_taken", 64'(in_taken), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_count", 64'(count), 64'd0);
        rst_n = 1'b1;

        cycle(4'b1111, p4(OA, OB, OC, OD), 4'b0000, 1'b0, got_t);
        check("fill_taken", 64'(got_t), 64'(4'b1111));
        check("fill_slots", 64'(instr_out), 64'(p4(OA, OB, OC, OD)));
        check("fill_count", 64'(count), 64'd4);

        cycle(4'b0011, p4(OE, OF, Z, Z), 4'b0101, 1'b0, got_t);
        check("sparse_taken", 64'(got_t), 64'(4'b0011));
        check("sparse_slots", 64'(instr_out), 64'(p4(OB, OD, OE, OF)));

        for (int r = 0; r < 3; r++) begin
            cycle(4'b1111, p4(OG, OH, OA, OB), 4'b0000, 1'b0, got_t);
            check("full_taken", 64'(got_t), 64'd0);
        end
        check("full_hold", 64'(instr_out), 64'(p4(OB, OD, OE, OF)));

        cycle(4'b0000, '0, 4'b1111, 1'b0, got_t);
        cycle(4'b0011, p4(OA, OB, Z, Z), 4'b0000, 1'b0, got_t);
        cycle(4'b0111, p4(OE, OF, OG, Z), 4'b0011, 1'b0, got_t);
        check("reuse_taken", 64'(got_t), 64'(4'b0111));
        check("reuse_slots", 64'(instr_out), 64'(p4(OE, OF, OG, Z)));
        check("reuse_count", 64'(count), 64'd3);

        cycle(4'b0000, '0, 4'b1111, 1'b0, got_t);
        cycle(4'b0001, p4(OA, Z, Z, Z), 4'b0000, 1'b0, got_t);
        cycle(4'b0000, '0, 4'b1110, 1'b0, got_t);
        check("ignore_used_count", 64'(count), 64'd1);
        check("ignore_used_slots", 64'(instr_out), 64'(p4(OA, Z, Z, Z)));
        cycle(4'b0111, p4(OB, OC, OD, Z), 4'b1110, 1'b0, got_t);
        check("ignore_used_refill", 64'(instr_out), 64'(p4(OA, OB, OC, OD)));

        for (int t = 0; t < 6; t++) begin
            logic [FW*SZ-1:0] ops;
            for (int j = 0; j < FW; j++) ops[j*SZ +: SZ] = SZ'(16'h0200 + t * 16 + j);
            cycle(tbl_vld[t], ops, tbl_used[t], 1'b0, got_t);
        end

`ifdef DISPATCH_BUF_FLUSH_EN
        cycle(4'b0000, '0, 4'b1111, 1'b0, got_t);
        cycle(4'b0111, p4(OA, OB, OC, Z), 4'b0000, 1'b0, got_t);
        check("pre_flush_count", 64'(count), 64'd3);
        cycle(4'b1111, p4(OE, OF, OG, OH), 4'b0001, 1'b1, got_t);
        check("flush_taken", 64'(got_t), 64'd0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(instr_valid), 64'd0);
`endif

        cycle(4'b1111, p4(OA, OB, OC, OD), 4'b1111, 1'b0, got_t);
        rst_n    = 1'b0;
        q.delete();
        in_valid = 4'b1111;
        #1;
        check("midreset_taken", 64'(in_taken), 64'd0);
        check("midreset_valid", 64'(instr_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(4'b0011, p4(OG, OH, Z, Z), 4'b0000, 1'b0, got_t);
        check("post_reset_slots", 64'(instr_out), 64'(p4(OG, OH, Z, Z)));

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dispatch_group_buffer.md
# dispatch_group_buffer

Holding buffer that feeds the dispatch type sorter: it presents up to FETCH_WIDTH renamed ops, oldest in slot 0, and receives back a per-slot used mask each cycle. Used slots are retired, survivors are compacted toward slot 0 in program order, and the freed tail is refilled from the rename stage's partially-consumable group interface. It is the producer side of the sorter's instr_in/instr_valid/instr_used protocol.

## Interface
- FETCH_WIDTH, 4: slot count; also the upstream group width; ≥2, power of two.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_ops  input  FETCH_WIDTH*`RENAMED_OP_SZ  upstream renamed ops, op i at bits [i*`RENAMED_OP_SZ +: `RENAMED_OP_SZ].
- in_valid  input  FETCH_WIDTH  upstream valid mask; always contiguous from bit 0.
- in_taken  output  FETCH_WIDTH  ops accepted this cycle; contiguous from bit 0, subset of in_valid.
- instr_out  output  FETCH_WIDTH*`RENAMED_OP_SZ  buffered ops to sorter, registered.
- instr_valid  output  FETCH_WIDTH  slot valid mask, registered, contiguous from bit 0.
- instr_used  input  FETCH_WIDTH  sorter's used mask for the current instr_out.
- count  output  $clog2(FETCH_WIDTH)+1  occupancy, registered.
- flush  input  1  only with DISPATCH_BUF_FLUSH_EN.

## Operation
- State: FETCH_WIDTH slot registers + valid bits; count equals popcount(instr_valid).
- Retire: r = instr_valid & instr_used; bits of instr_used on invalid slots ignored.
- Survivors s = count − popcount(r), compacted to slots 0..s−1 preserving relative order.
- Refill: k = min(popcount(in_valid), FETCH_WIDTH − s); in_taken = lowest k bits set; in_ops[0..k−1] written to slots s..s+k−1.
- Next count = s + k; slots ≥ s+k cleared (valid 0, data 0).
- in_taken is combinational from in_valid, instr_used and state; no path from in_ops.
- Full buffer with nothing used: in_taken = 0, state held.
- Empty buffer: up to FETCH_WIDTH ops accepted directly into slots 0..k−1.
- Non-contiguous used (e.g. 4'b0101) is legal; survivors slot1, slot3 move to slots 0, 1.
- No state machine beyond occupancy; every cycle performs retire+compact+refill.

## Timing
- Reset (async assert, sync deassert handled externally): instr_valid = 0, instr_out = 0, count = 0; in_taken = 0 while rst_n low.
- Op accepted in cycle N appears on instr_out/instr_valid in cycle N+1 (one-cycle latency).
- Op used in cycle N is absent from instr_valid in cycle N+1.
- Simultaneous retire and refill in one cycle: both apply; freed slots are reusable in the same cycle.
- Reset mid-operation: all buffered ops discarded; upstream must not treat the reset-cycle in_taken as acceptance.

## Configuration
- DISPATCH_BUF_FLUSH_EN defined: flush port exists; flush high at edge clears all slots, count → 0; in_taken forced 0 that cycle; instr_used ignored.
- Undefined: no flush port; only reset clears the buffer.

## Structure
- `RENAMED_OP_SZ` and opcode field positions come from the shared defines header; no new typedefs.
- Popcount/compaction helper as a shared function in the common package.
- One sub-module: dispatch_compact (combinational: valid mask + retire mask → per-slot source select and survivor count), reusing priority_enc.
- Register stage and refill muxing stay in dispatch_group_buffer.

## Test plan
- Reset then in_valid=4'b1111 ops A–D, used=0 -> in_taken=4'b1111; next cycle instr_valid=4'b1111, count=4, slots A,B,C,D.
- Full A–D, used=4'b0101, in_valid=4'b0011 E,F -> in_taken=4'b0011; next slots B,D,E,F.
- Full A–D, used=0, in_valid=4'b1111 -> in_taken=0; state unchanged for 3 cycles.
- Slots A,B (count 2), used=4'b0011, in_valid=4'b0111 E,F,G -> next slots E,F,G, count=3.
- Used bits on invalid slots (valid=4'b0001, used=4'b1110) -> nothing retired, count stays 1 (plus refill).
- With DISPATCH_BUF_FLUSH_EN: count=3, flush=1, in_valid=4'b1111 -> in_taken=0; next count=0, instr_valid=0.
